// File: rtl/vga_pixel_sink_pkg.sv
// rtl/vga_pixel_sink_pkg.sv - shared types and widths for the VGA pixel sink
package vga_pixel_sink_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam int CNT_W         = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TOP,
        STREAM,
        RESYNC
    } sink_state_t;

    // Occupancy needs one bit more than the address to represent "full".
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vga_pixel_sink_if.sv
// rtl/vga_pixel_sink_if.sv - upstream pixel stream into the sink
interface vga_pixel_sink_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] pix_in;
    logic              valid_in;
    logic              output_ready;

    modport master (
        output pix_in,
        output valid_in,
        input  output_ready
    );

    modport slave (
        input  pix_in,
        input  valid_in,
        output output_ready
    );

endinterface

// File: rtl/vga_pixel_sink_fifo.sv
// rtl/vga_pixel_sink_fifo.sv - synchronous pixel FIFO with wrap-bit pointers
module vga_pixel_sink_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/vga_pixel_sink.sv
// rtl/vga_pixel_sink.sv - buffers the filter stream and re-times it onto the visible raster
module vga_pixel_sink
    import vga_pixel_sink_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int PREFILL   = 8,
    parameter  int H_VISIBLE = H_VISIBLE_DEF,
    parameter  int V_VISIBLE = V_VISIBLE_DEF,
    localparam int LW        = level_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_pixel_sink_if.slave      s_if,
    input  logic [CNT_W-1:0]     hcount,
    input  logic [CNT_W-1:0]     vcount,
    input  logic                 visible,
    output logic [DATA_W-1:0]    pix_out,
    output logic                 pix_valid,
    output logic                 underflow,
    output logic [LW-1:0]        fifo_level
);

    sink_state_t       r_state;
    sink_state_t       w_next_state;
    logic              w_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_underflow;
    logic              w_full;
    logic              w_empty;
    logic              w_top;
    logic              w_last_px;
    logic [DATA_W-1:0] w_rdata;
    logic [LW-1:0]     w_level;
    logic [CNT_W-1:0]  r_in_x;
    logic [CNT_W-1:0]  r_in_y;
    logic [DATA_W-1:0] r_pix_out;
    logic              r_pix_valid;
    logic              r_underflow;

    // Ready depends only on registered state so upstream sees no comb loop.
    assign w_ready           = (r_state == RESYNC) || !w_full;
    assign s_if.output_ready = w_ready;
    assign w_accept          = s_if.valid_in && w_ready;
    assign w_push            = w_accept && (r_state != RESYNC);
    assign w_top             = visible && (hcount == '0) && (vcount == '0);
    assign w_last_px         = (r_in_x == CNT_W'(H_VISIBLE - 1)) && (r_in_y == CNT_W'(V_VISIBLE - 1));

    vga_pixel_sink_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (s_if.pix_in),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_underflow  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_level >= LW'(PREFILL)) w_next_state = WAIT_TOP;
            end
            WAIT_TOP: begin
                if (w_top) begin
                    w_pop        = !w_empty;
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (visible) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_underflow  = 1'b1;
                        w_next_state = RESYNC;
                    end
                end
            end
            RESYNC: begin
                // Drop input until the upstream frame wraps, so the next frame lands at (0,0).
                w_flush = 1'b1;
                if (((r_in_x == '0) && (r_in_y == '0)) || (w_accept && w_last_px))
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_x <= '0;
            r_in_y <= '0;
        end else if (w_accept) begin
            if (r_in_x == CNT_W'(H_VISIBLE - 1)) begin
                r_in_x <= '0;
                r_in_y <= (r_in_y == CNT_W'(V_VISIBLE - 1)) ? '0 : r_in_y + 1'b1;
            end else begin
                r_in_x <= r_in_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_out   <= '0;
            r_pix_valid <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pix_out   <= w_pop ? w_rdata : '0;
            r_pix_valid <= w_pop;
            r_underflow <= w_underflow;
        end
    end

    assign pix_out    = r_pix_out;
    assign pix_valid  = r_pix_valid;
    assign underflow  = r_underflow;
    assign fifo_level = w_level;

endmodule
